// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing for the button conditioner.
// Timing defaults are derived from the 125 MHz system clock.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } btn_state_t;

  typedef struct packed {
    btn_state_t inc;
    btn_state_t dec;
  } dbg_state_t;

  localparam int unsigned CLK_FREQ            = 125000000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_FREQ / 50;  // 20 ms
  localparam int unsigned DEF_HOLD_CYCLES     = CLK_FREQ / 2;   // 0.5 s
  localparam int unsigned DEF_REPEAT_CYCLES   = CLK_FREQ / 5;   // 0.2 s

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce filter and press/repeat FSM.
// The pulse output is combinational; the top registers it after mutual exclusion.
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          ENABLE_REPEAT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  output logic       level,
  output logic       pulse,
  output btn_state_t state
);

  localparam logic [31:0] DB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

  logic [1:0]  sync_q;
  logic [31:0] db_cnt;
  logic [31:0] hold_cnt;
  logic [31:0] hold_cnt_d;
  btn_state_t  state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      level  <= 1'b0;
      db_cnt <= 32'd0;
    end else begin
      sync_q <= {sync_q[0], raw};
      // Any cycle that agrees with the current level restarts the filter.
      if (sync_q[1] == level) begin
        db_cnt <= 32'd0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync_q[1];
        db_cnt <= 32'd0;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RELEASED;
      hold_cnt <= 32'd0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    case (state)
      RELEASED: begin
        hold_cnt_d = 32'd0;
        if (level) state_d = HELD;
      end
      HELD: begin
        if (!level) begin
          state_d    = RELEASED;
          hold_cnt_d = 32'd0;
        end else if (hold_cnt == HOLD_LAST) begin
          // Without repeat the counter parks at its last value until release.
          if (ENABLE_REPEAT) begin
            state_d    = REPEATING;
            hold_cnt_d = 32'd0;
          end
        end else begin
          hold_cnt_d = hold_cnt + 32'd1;
        end
      end
      REPEATING: begin
        if (!level) begin
          state_d    = RELEASED;
          hold_cnt_d = 32'd0;
        end else if (hold_cnt == REPEAT_LAST) begin
          hold_cnt_d = 32'd0;
        end else begin
          hold_cnt_d = hold_cnt + 32'd1;
        end
      end
      default: begin
        state_d    = RELEASED;
        hold_cnt_d = 32'd0;
      end
    endcase
  end

  always_comb begin
    pulse = 1'b0;
    case (state)
      RELEASED:  pulse = level;
      HELD:      pulse = level && ENABLE_REPEAT && (hold_cnt == HOLD_LAST);
      REPEATING: pulse = level && (hold_cnt == REPEAT_LAST);
      default:   pulse = 1'b0;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Two debounced button channels with mutual exclusion and registered one-cycle pulses.
// A channel's pulse is dropped while the other channel's debounced level is high.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          ENABLE_REPEAT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc_raw,
  input  logic       btn_dec_raw,
  output logic       btn_inc,
  output logic       btn_dec,
  output logic       inc_level,
  output logic       dec_level,
  output dbg_state_t dbg_state
);

  logic inc_pulse;
  logic dec_pulse;

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .ENABLE_REPEAT  (ENABLE_REPEAT)
  ) u_inc (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_inc_raw),
    .level(inc_level),
    .pulse(inc_pulse),
    .state(dbg_state.inc)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .ENABLE_REPEAT  (ENABLE_REPEAT)
  ) u_dec (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_dec_raw),
    .level(dec_level),
    .pulse(dec_pulse),
    .state(dbg_state.dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_inc <= 1'b0;
      btn_dec <= 1'b0;
    end else begin
      btn_inc <= inc_pulse & ~dec_level;
      btn_dec <= dec_pulse & ~inc_level;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing (debounce 4, hold 20, repeat 8).
// Pulse cycles are logged relative to the cycle the stimulus changed and compared to exp_q.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       inc_raw = 1'b0;
  logic       dec_raw = 1'b0;
  logic       nr_inc_raw = 1'b0;
  logic       nr_dec_raw = 1'b0;
  logic       btn_inc, btn_dec, inc_level, dec_level;
  logic       nr_btn_inc, nr_btn_dec, nr_inc_level, nr_dec_level;
  dbg_state_t dbg_state, nr_dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int consec = 0;
  int inc_rise, inc_fall, inc_rises;
  logic prev_inc = 1'b0, prev_dec = 1'b0, prev_nr = 1'b0, prev_lvl = 1'b0;
  int inc_q[$];
  int dec_q[$];
  int nr_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .ENABLE_REPEAT(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_inc_raw(inc_raw), .btn_dec_raw(dec_raw),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .inc_level(inc_level), .dec_level(dec_level),
    .dbg_state(dbg_state)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .ENABLE_REPEAT(1'b0)
  ) u_norep (
    .clk(clk), .rst_n(rst_n), .btn_inc_raw(nr_inc_raw), .btn_dec_raw(nr_dec_raw),
    .btn_inc(nr_btn_inc), .btn_dec(nr_btn_dec), .inc_level(nr_inc_level),
    .dec_level(nr_dec_level), .dbg_state(nr_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (btn_inc) inc_q.push_back(cyc);
    if (btn_dec) dec_q.push_back(cyc);
    if (nr_btn_inc) nr_q.push_back(cyc);
    if ((btn_inc && prev_inc) || (btn_dec && prev_dec) || (nr_btn_inc && prev_nr)) consec++;
    if (inc_level && !prev_lvl) begin
      inc_rises++;
      inc_rise = cyc;
    end
    if (!inc_level && prev_lvl) inc_fall = cyc;
    prev_inc = btn_inc;
    prev_dec = btn_dec;
    prev_nr  = nr_btn_inc;
    prev_lvl = inc_level;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_test();
    inc_q.delete();
    dec_q.delete();
    nr_q.delete();
    cyc = 0;
    inc_rises = 0;
    inc_rise = -1;
    inc_fall = -1;
  endtask

  task automatic check_pulses(input string tag, input int got_q[$]);
    check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      check($sformatf("%s_%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, exp_q[i]);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #3;
    check("rst_btn_inc", {31'd0, btn_inc}, 32'd0);
    check("rst_btn_dec", {31'd0, btn_dec}, 32'd0);
    check("rst_inc_level", {31'd0, inc_level}, 32'd0);
    check("rst_dec_level", {31'd0, dec_level}, 32'd0);
    check("rst_state", {28'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_test();
    run(1);
    check("first_cycle_no_pulse", {31'd0, btn_inc | btn_dec}, 32'd0);
    run(5);

    // Clean press held 10 cycles
    start_test();
    inc_raw = 1'b1;
    run(10);
    inc_raw = 1'b0;
    run(20);
    check("clean_rise_cyc", 32'(inc_rise), 32'd6);
    check("clean_fall_cyc", 32'(inc_fall), 32'd16);
    exp_q = {32'd7};
    check_pulses("clean_inc", inc_q);
    check("clean_dec_count", 32'(dec_q.size()), 32'd0);

    // Bounce every 2 cycles never settles long enough
    start_test();
    repeat (8) begin
      inc_raw = 1'b1;
      run(2);
      inc_raw = 1'b0;
      run(2);
    end
    run(20);
    check("bounce_rises", 32'(inc_rises), 32'd0);
    exp_q = {};
    check_pulses("bounce_inc", inc_q);

    // Long hold with auto-repeat
    start_test();
    inc_raw = 1'b1;
    run(60);
    inc_raw = 1'b0;
    run(20);
    exp_q = {32'd7, 32'd27, 32'd35, 32'd43, 32'd51, 32'd59};
    check_pulses("repeat_inc", inc_q);
    check("repeat_fall_cyc", 32'(inc_fall), 32'd66);

    // Inc pressed while dec held
    start_test();
    dec_raw = 1'b1;
    run(10);
    inc_raw = 1'b1;
    run(4);
    dec_raw = 1'b0;
    run(6);
    inc_raw = 1'b0;
    run(25);
    exp_q = {32'd7};
    check_pulses("mutex_dec", dec_q);
    exp_q = {};
    check_pulses("mutex_inc", inc_q);
    check("mutex_inc_rise", 32'(inc_rise), 32'd16);

    // Both pressed on the same cycle
    start_test();
    inc_raw = 1'b1;
    dec_raw = 1'b1;
    run(10);
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    run(20);
    check("both_inc_rise", 32'(inc_rise), 32'd6);
    check("both_inc_count", 32'(inc_q.size()), 32'd0);
    check("both_dec_count", 32'(dec_q.size()), 32'd0);

    // Reset in the middle of a held press
    start_test();
    inc_raw = 1'b1;
    run(12);
    exp_q = {32'd7};
    check_pulses("prereset_inc", inc_q);
    rst_n = 1'b0;
    #1;
    check("midrst_inc_level", {31'd0, inc_level}, 32'd0);
    check("midrst_btn_inc", {31'd0, btn_inc}, 32'd0);
    check("midrst_state", {28'd0, dbg_state}, 32'd0);
    run(3);
    rst_n = 1'b1;
    start_test();
    run(15);
    exp_q = {32'd7};
    check_pulses("postrst_inc", inc_q);
    check("postrst_rise_cyc", 32'(inc_rise), 32'd6);
    inc_raw = 1'b0;
    run(20);

    // Repeat disabled: one pulse for a long hold
    start_test();
    nr_inc_raw = 1'b1;
    run(100);
    check("norep_state_held", {30'd0, nr_dbg_state.inc}, {30'd0, HELD});
    nr_inc_raw = 1'b0;
    run(20);
    exp_q = {32'd7};
    check_pulses("norep_inc", nr_q);

    check("no_consecutive_pulse", 32'(consec), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
